// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory arbiter.
//   state_t     - sequencer states (IDLE/RD/WR/GAP)
//   LEN_*       - LS length codes (byte count minus one)
//   IO_SEL      - address bits [17:16] value selecting the IO region
//   REG_DAT_W / INS_DAT_W - address/data and instruction widths
package mem_arb_pkg;
    localparam int REG_DAT_W = 32;
    localparam int INS_DAT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    localparam logic [1:0] LEN_B  = 2'd0;
    localparam logic [1:0] LEN_H  = 2'd1;
    localparam logic [1:0] LEN_W  = 2'd3;
    localparam logic [1:0] IO_SEL = 2'b11;

    function automatic logic is_io(input logic [1:0] sel);
        return sel == IO_SEL;
    endfunction

    // Code 2 has no 3-byte meaning; it is widened to a full word.
    function automatic logic [1:0] norm_len(input logic [1:0] l);
        case (l)
            LEN_B:   return LEN_B;
            LEN_H:   return LEN_H;
            default: return LEN_W;
        endcase
    endfunction
endpackage

// File: rtl/mem_arb_if.sv
// mem_arb_if: client-side bundle of the arbiter (IC fetch and LS access).
//   slave  modport - the arbiter (takes requests, returns done/data)
//   master modport - the clients (IC fetch unit, load/store unit)
interface mem_arb_if;
    import mem_arb_pkg::*;

    logic                 iIC_En;
    logic [REG_DAT_W-1:0] iIC_Addr;
    logic                 oIC_En;
    logic [INS_DAT_W-1:0] oIC_Ins;

    logic                 iLS_En;
    logic                 iLS_Wr;
    logic [1:0]           iLS_Len;
    logic [REG_DAT_W-1:0] iLS_Addr;
    logic [REG_DAT_W-1:0] iLS_Dat;
    logic                 oLS_En;
    logic [REG_DAT_W-1:0] oLS_Dat;

    modport slave (
        input  iIC_En, iIC_Addr, iLS_En, iLS_Wr, iLS_Len, iLS_Addr, iLS_Dat,
        output oIC_En, oIC_Ins, oLS_En, oLS_Dat
    );

    modport master (
        output iIC_En, iIC_Addr, iLS_En, iLS_Wr, iLS_Len, iLS_Addr, iLS_Dat,
        input  oIC_En, oIC_Ins, oLS_En, oLS_Dat
    );
endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: winner selector between LS and IC requests.
//   ls_req/ic_req in  - qualified requests
//   gnt_ls/gnt_ic out - one-hot (or none) grant, combinational
// With MEM_ARB_FAIR_EN defined the block is round-robin and adds
// clk/rst/upd ports; otherwise LS has fixed priority.
module mem_arb_pick (
`ifdef MEM_ARB_FAIR_EN
    input  logic clk,
    input  logic rst,
    input  logic upd,
`endif
    input  logic ls_req,
    input  logic ic_req,
    output logic gnt_ls,
    output logic gnt_ic
);
`ifdef MEM_ARB_FAIR_EN
    // Turn only moves on contention: the loser of the last tie wins the
    // next one. Reset leaves LS favoured.
    logic ic_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          ic_next <= 1'b0;
        else if (upd && ls_req && ic_req) ic_next <= ~ic_next;
    end

    always_comb begin
        gnt_ls = ls_req && !(ic_req && ic_next);
        gnt_ic = ic_req && !(ls_req && !ic_next);
    end
`else
    assign gnt_ls = ls_req;
    assign gnt_ic = ic_req && !ls_req;
`endif
endmodule

// File: rtl/mem_arb.sv
// mem_arb: single-port byte-bus arbiter/sequencer for IC fetch and LS access.
//   clk, rst (async, high)   - clock and reset
//   en                       - global ready; low freezes all state
//   iClr                     - flush, aborts an IC read only
//   bus (mem_arb_if.slave)   - IC/LS requests and done/data returns
//   iRAM_Din, iRAM_IoFull    - read byte (one cycle after address), IO full
//   oRAM_A, oRAM_Wr, oRAM_Dout - byte address, write strobe, write byte
// Optional macro MEM_ARB_FAIR_EN selects round-robin arbitration.
module mem_arb
    import mem_arb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 iClr,
    mem_arb_if.slave             bus,
    input  logic [7:0]           iRAM_Din,
    input  logic                 iRAM_IoFull,
    output logic [REG_DAT_W-1:0] oRAM_A,
    output logic                 oRAM_Wr,
    output logic [7:0]           oRAM_Dout
);
    state_t               state, state_n;
    logic [2:0]           cnt, cnt_n;
    logic [REG_DAT_W-1:0] base, wdat, rdat;
    logic [1:0]           len_q;
    logic                 own_ic;

    logic gnt_ls, gnt_ic, grant;
    logic [2:0] n_last;
    logic addr_ph, wr_ph, stall, rd_done, wr_done, abort, cap;
    logic [1:0] cap_idx;

    mem_arb_pick u_pick (
`ifdef MEM_ARB_FAIR_EN
        .clk    (clk),
        .rst    (rst),
        .upd    (en && state == ST_IDLE),
`endif
        .ls_req (bus.iLS_En),
        .ic_req (bus.iIC_En && !iClr),
        .gnt_ls (gnt_ls),
        .gnt_ic (gnt_ic)
    );

    // RD spans n address cycles, one trailing capture cycle, then the done
    // cycle; WR spans n byte cycles then the done cycle.
    always_comb begin
        grant   = state == ST_IDLE && (gnt_ls || gnt_ic);
        n_last  = {1'b0, len_q};
        addr_ph = (state == ST_RD || state == ST_WR) && cnt <= n_last;
        wr_ph   = state == ST_WR && cnt <= n_last;
        stall   = wr_ph && is_io(base[17:16]) && iRAM_IoFull;
        rd_done = state == ST_RD && cnt == n_last + 3'd2;
        wr_done = state == ST_WR && cnt == n_last + 3'd1;
        abort   = state == ST_RD && own_ic && iClr;
        cap     = state == ST_RD && cnt != 3'd0 && cnt <= n_last + 3'd1;
        cap_idx = cnt[1:0] - 2'd1;
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            ST_IDLE: begin
                cnt_n = '0;
                if (gnt_ls)      state_n = bus.iLS_Wr ? ST_WR : ST_RD;
                else if (gnt_ic) state_n = ST_RD;
            end
            ST_RD: begin
                if (abort || rd_done) state_n = ST_GAP;
                else                  cnt_n   = cnt + 3'd1;
            end
            ST_WR: begin
                if (wr_done)     state_n = ST_GAP;
                else if (!stall) cnt_n   = cnt + 3'd1;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            base   <= '0;
            len_q  <= '0;
            wdat   <= '0;
            rdat   <= '0;
            own_ic <= 1'b0;
        end else if (en) begin
            state <= state_n;
            cnt   <= cnt_n;
            if (grant) begin
                own_ic <= !gnt_ls;
                base   <= gnt_ls ? bus.iLS_Addr : bus.iIC_Addr;
                len_q  <= gnt_ls ? norm_len(bus.iLS_Len) : LEN_W;
                wdat   <= bus.iLS_Dat;
                rdat   <= '0;  // short loads come back zero-extended
            end else if (cap) begin
                rdat[{cap_idx, 3'b000} +: 8] <= iRAM_Din;
            end
        end
    end

    // Done pulses are decoded from held state, so a frozen bus keeps them.
    always_comb begin
        bus.oIC_En  = rd_done && own_ic && !iClr;
        bus.oLS_En  = (rd_done && !own_ic) || wr_done;
        bus.oIC_Ins = rdat[INS_DAT_W-1:0];
        bus.oLS_Dat = rdat;
        oRAM_A      = addr_ph ? base + REG_DAT_W'(cnt) : '0;
        oRAM_Wr     = wr_ph && !stall && en;
        oRAM_Dout   = wr_ph ? wdat[{cnt[1:0], 3'b000} +: 8] : 8'h00;
    end
endmodule

// File: tb/tb_mem_arb.sv
module tb_mem_arb;
    localparam int LOGN = 24;

    logic        clk, rst, en, iClr, iRAM_IoFull;
    logic [7:0]  iRAM_Din, oRAM_Dout;
    logic [31:0] oRAM_A;
    logic        oRAM_Wr;

    mem_arb_if bus();

    mem_arb dut (
        .clk(clk), .rst(rst), .en(en), .iClr(iClr), .bus(bus),
        .iRAM_Din(iRAM_Din), .iRAM_IoFull(iRAM_IoFull),
        .oRAM_A(oRAM_A), .oRAM_Wr(oRAM_Wr), .oRAM_Dout(oRAM_Dout)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ram_byte(input logic [31:0] a);
        case (a)
            32'h1000: return 8'h13;
            32'h1001, 32'h1002, 32'h1003: return 8'h00;
            32'h2000: return 8'h78;
            32'h2001: return 8'h56;
            32'h2002: return 8'h34;
            32'h2003: return 8'h12;
            default:  return a[7:0] ^ 8'hA5;
        endcase
    endfunction

    // RAM returns the byte for an address one cycle later
    always @(posedge clk) iRAM_Din <= ram_byte(oRAM_A);

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    logic [31:0] a_log [LOGN];
    logic        wr_log[LOGN];
    logic [7:0]  d_log [LOGN];
    logic        ice_log[LOGN], lse_log[LOGN];
    logic [31:0] ins_log[LOGN], lsd_log[LOGN];

    task automatic clr_log();
        for (int c = 0; c < LOGN; c++) begin
            a_log[c] = '0; wr_log[c] = 0; d_log[c] = '0;
            ice_log[c] = 0; lse_log[c] = 0; ins_log[c] = '0; lsd_log[c] = '0;
        end
    endtask

    // Called at posedge+1 of cycle c0; samples each cycle mid-way and
    // drops a request once its done pulse was seen.
    task automatic capture(input int c0, input int n);
        for (int c = c0; c < c0 + n; c++) begin
            @(negedge clk);
            a_log[c] = oRAM_A; wr_log[c] = oRAM_Wr; d_log[c] = oRAM_Dout;
            ice_log[c] = bus.oIC_En; lse_log[c] = bus.oLS_En;
            ins_log[c] = bus.oIC_Ins; lsd_log[c] = bus.oLS_Dat;
            @(posedge clk); #1;
            if (ice_log[c]) bus.iIC_En = 0;
            if (lse_log[c]) bus.iLS_En = 0;
        end
    endtask

    function automatic int first_hit(input bit ls);
        for (int c = 0; c < LOGN; c++)
            if (ls ? lse_log[c] : ice_log[c]) return c;
        return -1;
    endfunction

    function automatic int n_wr();
        int k = 0;
        for (int c = 0; c < LOGN; c++) if (wr_log[c]) k++;
        return k;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ls_req(input bit wr, input logic [1:0] len, input logic [31:0] a, input logic [31:0] d);
        bus.iLS_En = 1; bus.iLS_Wr = wr; bus.iLS_Len = len; bus.iLS_Addr = a; bus.iLS_Dat = d;
    endtask

`ifdef MEM_ARB_FAIR_EN
    localparam int PAIR2_LS = 11, PAIR2_IC = 6;
`else
    localparam int PAIR2_LS = 3, PAIR2_IC = 11;
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; en = 1; iClr = 0; iRAM_IoFull = 0;
        bus.iIC_En = 0; bus.iIC_Addr = '0;
        bus.iLS_En = 0; bus.iLS_Wr = 0; bus.iLS_Len = '0; bus.iLS_Addr = '0; bus.iLS_Dat = '0;
        #12;
        chk("rst_a",   oRAM_A, 0);
        chk("rst_wr",  oRAM_Wr, 0);
        chk("rst_do",  oRAM_Dout, 0);
        chk("rst_ice", bus.oIC_En, 0);
        chk("rst_lse", bus.oLS_En, 0);
        chk("rst_ins", bus.oIC_Ins, 0);
        chk("rst_lsd", bus.oLS_Dat, 0);
        @(posedge clk); #1; rst = 0;
        idle(2);

        // IC word fetch
        clr_log();
        bus.iIC_En = 1; bus.iIC_Addr = 32'h1000;
        capture(0, 10);
        chk("ic_a0", a_log[0], 0);
        for (int k = 0; k < 4; k++) chk($sformatf("ic_a%0d", k + 1), a_log[k + 1], 32'h1000 + k);
        chk("ic_a5", a_log[5], 0);
        chk("ic_done", first_hit(0), 6);
        chk("ic_ins", ins_log[6], 32'h13);
        chk("ic_nowr", n_wr(), 0);
        chk("ic_nols", first_hit(1), -1);
        idle(2);

        // contention: LS word load vs IC fetch
        clr_log();
        bus.iIC_En = 1; bus.iIC_Addr = 32'h1000;
        ls_req(0, 2'd3, 32'h2000, 0);
        capture(0, 16);
        chk("pr_lsa", a_log[1], 32'h2000);
        chk("pr_lsdone", first_hit(1), 6);
        chk("pr_lsd", lsd_log[6], 32'h12345678);
        chk("pr_gap", a_log[8], 0);
        chk("pr_ica", a_log[9], 32'h1000);
        chk("pr_icdone", first_hit(0), 14);
        chk("pr_ins", ins_log[14], 32'h13);
        idle(2);

        // second contention: LS byte load at 0x2001 vs IC fetch
        clr_log();
        bus.iIC_En = 1; bus.iIC_Addr = 32'h1000;
        ls_req(0, 2'd0, 32'h2001, 0);
        capture(0, 14);
        chk("pr2_ls", first_hit(1), PAIR2_LS);
        chk("pr2_ic", first_hit(0), PAIR2_IC);
        chk("pr2_lsd", lsd_log[PAIR2_LS], 32'h56);
        idle(2);

        // halfword store
        clr_log();
        ls_req(1, 2'd1, 32'h3000, 32'h1234BEEF);
        capture(0, 6);
        chk("hw_a1", a_log[1], 32'h3000);
        chk("hw_w1", wr_log[1], 1);
        chk("hw_d1", d_log[1], 8'hEF);
        chk("hw_a2", a_log[2], 32'h3001);
        chk("hw_w2", wr_log[2], 1);
        chk("hw_d2", d_log[2], 8'hBE);
        chk("hw_nwr", n_wr(), 2);
        chk("hw_done", first_hit(1), 3);
        idle(2);

        // IO byte store with buffer full in cycles 1..3
        clr_log();
        ls_req(1, 2'd0, 32'h30000, 32'h0000005C);
        capture(0, 1);
        iRAM_IoFull = 1;
        capture(1, 3);
        iRAM_IoFull = 0;
        capture(4, 4);
        chk("io_hold_a", a_log[3], 32'h30000);
        chk("io_w4", wr_log[4], 1);
        chk("io_d4", d_log[4], 8'h5C);
        chk("io_nwr", n_wr(), 1);
        chk("io_done", first_hit(1), 5);
        idle(2);

        // flush in cycle 3 of an IC fetch, LS load pending from then on
        clr_log();
        bus.iIC_En = 1; bus.iIC_Addr = 32'h1000;
        capture(0, 3);
        iClr = 1; bus.iIC_En = 0;
        ls_req(0, 2'd0, 32'h2000, 0);
        capture(3, 1);
        iClr = 0;
        capture(4, 8);
        chk("cl_noic", first_hit(0), -1);
        chk("cl_gap", a_log[4], 0);
        chk("cl_lsa", a_log[6], 32'h2000);
        chk("cl_done", first_hit(1), 8);
        chk("cl_lsd", lsd_log[8], 32'h78);
        idle(2);

        // en low during the first store byte
        clr_log();
        ls_req(1, 2'd0, 32'h5000, 32'h000000AB);
        capture(0, 1);
        en = 0;
        capture(1, 1);
        en = 1;
        capture(2, 4);
        chk("en_w1", wr_log[1], 0);
        chk("en_w2", wr_log[2], 1);
        chk("en_d2", d_log[2], 8'hAB);
        chk("en_nwr", n_wr(), 1);
        chk("en_done", first_hit(1), 3);
        idle(2);

        // word load wrapping past 0xFFFFFFFF
        clr_log();
        ls_req(0, 2'd3, 32'hFFFFFFFE, 0);
        capture(0, 8);
        chk("wr_a2", a_log[2], 32'hFFFFFFFF);
        chk("wr_a3", a_log[3], 32'h0);
        chk("wr_done", first_hit(1), 6);
        chk("wr_lsd", lsd_log[6], 32'hA4A55A5B);
        idle(2);

        // illegal length 2 behaves as a word
        clr_log();
        ls_req(0, 2'd2, 32'h2000, 0);
        capture(0, 8);
        chk("l2_a4", a_log[4], 32'h2003);
        chk("l2_done", first_hit(1), 6);
        chk("l2_lsd", lsd_log[6], 32'h12345678);
        idle(2);

        // reset in the middle of a word store
        clr_log();
        ls_req(1, 2'd3, 32'h4000, 32'hCAFEF00D);
        capture(0, 3);
        chk("rm_w1", wr_log[1], 1);
        rst = 1; bus.iLS_En = 0;
        #1;
        chk("rm_a", oRAM_A, 0);
        chk("rm_wr", oRAM_Wr, 0);
        chk("rm_do", oRAM_Dout, 0);
        chk("rm_lse", bus.oLS_En, 0);
        @(posedge clk); #1; rst = 0;
        idle(1);
        clr_log();
        ls_req(0, 2'd0, 32'h2002, 0);
        capture(0, 6);
        chk("rm_a1", a_log[1], 32'h2002);
        chk("rm_done", first_hit(1), 3);
        chk("rm_lsd", lsd_log[3], 32'h34);
        chk("rm_nowr", n_wr(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
